// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes {bout, diff} = a - b - bin one bit per clock, LSB first.
// Three-state FSM (IDLE/SHIFT/DONE); dbg_state exposes the current state for observation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_n;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_n;
    logic             load;
    logic             last;

    // Full-subtractor on the current LSBs; the new difference bit enters at the MSB.
    always_comb begin
        d     = a_sr[0] ^ b_sr[0] ^ br;
        br_n  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_n = (res_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last  = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                a_sr   <= a;
                b_sr   <= b;
                res_sr <= '0;
                br     <= bin;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= res_n;
                br     <= br_n;
                cnt    <= cnt + CW'(1);
                // Publish on the same edge that enters DONE.
                if (last) begin
                    diff <= res_n;
                    bout <= br_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed and random operations on an 8-bit instance,
// plus a full truth-table sweep of a 1-bit instance, checked against arithmetic a-b-bin.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic [1:0] dbg_state;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       bin1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;
    logic [1:0] dbg_state1;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .dbg_state(dbg_state)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .dbg_state(dbg_state1)
    );

    // Reference: {borrow, difference} of plain integer subtraction.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return {(r < 0), r[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Start is sampled at the next posedge (edge 1); done is expected
    // to be observed at the negedge following edge 9, with busy seen high on exactly 8 negedges.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input int pulse_at, input bit hold);
        logic [8:0] e;
        int         lat;
        int         busy_n;
        exp_q.push_back(ref_sub(ta, tb, tbin));
        a      = ta;
        b      = tb;
        bin    = tbin;
        start  = 1'b1;
        lat    = 0;
        busy_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!hold) begin
                start = 1'b0;
                a     = 8'($urandom);
                b     = 8'($urandom);
                bin   = 1'($urandom);
            end
            if (pulse_at == n) begin
                start = 1'b1;
                a     = ~ta;
                b     = ~tb;
            end
            if (busy) busy_n++;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, 9);
        check("busy_cycles", busy_n, 8);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("diff", diff, e[7:0]);
            check("bout", bout, e[8]);
        end
    endtask

    initial begin
        int lat;
        int done_seen;
        int r;

        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        bin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        bin1   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_state", dbg_state, 0);
        check("rst_w1_busy", busy1, 0);
        check("rst_w1_diff", diff1, 0);
        rst = 1'b0;

        // Start issued straight after reset release.
        run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_diff", diff, 8'h02);
        check("hold_done", done, 0);

        run_op(8'h00, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 0, 1'b0);

        // Start re-pulsed 3 cycles in with different operands must be ignored.
        run_op(8'h3C, 8'h11, 1'b0, 3, 1'b0);

        // Reset 4 cycles into an operation aborts it.
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        bin   = 1'b0;
        start = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_diff_held", diff, 0);
        run_op(8'hAA, 8'h55, 1'b0, 0, 1'b0);

        // Start held through DONE: second operation follows with no IDLE cycle.
        @(negedge clk);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b1);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Random operations, issued back to back from DONE.
        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        // WIDTH=1 truth-table sweep.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            bin1   = 1'(i);
            start1 = 1'b1;
            lat    = 0;
            for (int n = 1; n <= 10; n++) begin
                @(posedge clk);
                @(negedge clk);
                start1 = 1'b0;
                if (done1) begin
                    lat = n;
                    break;
                end
            end
            r = int'(a1) - int'(b1) - int'(bin1);
            check("w1_latency", lat, 2);
            check("w1_diff", diff1, r[0]);
            check("w1_bout", bout1, (r < 0));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
